// File: rtl/data_sram_resp.sv
// data_sram_resp -- data-side SRAM responder.
//
// Word-organised RAM (2**ADDR_W x 32 bit) with byte-lane writes, registered
// read data and WAIT_CYCLES programmable wait states per access.
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   data_sram_en     access request this cycle
//   data_sram_wen    byte write enables (4'b0000 with en=1 is a read)
//   data_sram_addr   byte address; word index = addr[ADDR_W+1:2]
//   data_sram_wdata  lane-aligned store data
//   data_sram_rdata  registered read data, valid the cycle after the perform edge
//   stallreq         combinational stall request while an access is pending
module data_sram_resp #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stallreq
);

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t             state;
   logic [3:0]         cnt;
   logic [3:0]         req_wen;
   logic [ADDR_W-1:0]  req_idx;
   logic [31:0]        req_wdata;

   logic [3:0][7:0]    mem [DEPTH];

   logic [ADDR_W-1:0]  bus_idx;
   logic               perf;
   logic [3:0]         perf_wen;
   logic [ADDR_W-1:0]  perf_idx;
   logic [31:0]        perf_wdata;

   // High address bits alias; byte offset is ignored.
   logic               unused_addr;
   assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

   assign bus_idx = data_sram_addr[ADDR_W+1:2];

   // Select which access (live bus or latched request) is performed at the
   // coming edge. Everything is gated by rst so an aborted access never
   // touches memory or rdata.
   always_comb begin
      stallreq   = 1'b0;
      perf       = 1'b0;
      perf_wen   = data_sram_wen;
      perf_idx   = bus_idx;
      perf_wdata = data_sram_wdata;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (data_sram_en) begin
                  if (WAIT_CYCLES == 0) perf     = 1'b1;
                  else                  stallreq = 1'b1;
               end
            end
            WAIT: begin
               stallreq = (cnt != 4'd0);
               if (cnt == 4'd0) begin
                  perf       = 1'b1;
                  perf_wen   = req_wen;
                  perf_idx   = req_idx;
                  perf_wdata = req_wdata;
               end
            end
            default: ;
         endcase
      end
   end

   // Control FSM and read-data register.
   // en is not latched: WAIT is only entered with en=1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= 4'd0;
         req_wen         <= 4'd0;
         req_idx         <= '0;
         req_wdata       <= 32'd0;
         data_sram_rdata <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (data_sram_en && WAIT_CYCLES != 0) begin
                  state     <= WAIT;
                  cnt       <= CNT_INIT;
                  req_wen   <= data_sram_wen;
                  req_idx   <= bus_idx;
                  req_wdata <= data_sram_wdata;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) cnt   <= cnt - 4'd1;
               else             state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (perf && perf_wen == 4'd0)
            data_sram_rdata <= mem[perf_idx];
      end
   end

   // Memory array is deliberately not reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (perf) begin
         for (int i = 0; i < 4; i++)
            if (perf_wen[i]) mem[perf_idx][i] <= perf_wdata[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: two instances (no wait states with a 16-word
// memory for aliasing, and 3 wait states with a 4096-word memory), a
// transaction-level reference model checked every cycle, plus literal checks.
module tb_data_sram_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        en0, en3;
   logic [3:0]  wen;
   logic [31:0] addr, wdata;
   logic [31:0] rd0, rd3;
   logic        st0, st3;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   data_sram_resp #(.ADDR_W(4), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst), .data_sram_en(en0), .data_sram_wen(wen),
      .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_rdata(rd0), .stallreq(st0));

   data_sram_resp #(.ADDR_W(12), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst), .data_sram_en(en3), .data_sram_wen(wen),
      .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_rdata(rd3), .stallreq(st3));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Each access accepted in cycle c stalls cycles c .. c+W-1 and takes
   // effect at the edge closing cycle c+W. Memory is a sparse word map.
   int          WC [2] = '{0, 3};
   int          AW [2] = '{4, 12};
   int          cyc = 0;
   logic        pend [2];
   int          acc_c [2];
   logic [3:0]  p_wen [2];
   logic [31:0] p_addr [2];
   logic [31:0] p_wd [2];
   logic [31:0] exp_rd [2] = '{32'd0, 32'd0};
   logic [31:0] mm [int];

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic        en_d, est, ast;
         logic [31:0] ard, w;
         int          key;
         en_d = (d == 1) ? en3 : en0;
         ard  = (d == 1) ? rd3 : rd0;
         ast  = (d == 1) ? st3 : st0;
         est  = 1'b0;
         if (rst) begin
            pend[d]   = 1'b0;
            exp_rd[d] = 32'd0;
         end else begin
            if (!pend[d] && en_d) begin
               pend[d]   = 1'b1;
               acc_c[d]  = cyc;
               p_wen[d]  = wen;
               p_addr[d] = addr;
               p_wd[d]   = wdata;
            end
            est = pend[d] && (cyc < acc_c[d] + WC[d]);
         end
         chk((d == 1) ? "model rdata w3" : "model rdata w0", ard, exp_rd[d]);
         chk((d == 1) ? "model stall w3" : "model stall w0", {31'd0, ast}, {31'd0, est});
         if (!rst && pend[d] && cyc == acc_c[d] + WC[d]) begin
            key = d * (1 << 20) + int'((p_addr[d] >> 2) & ((32'd1 << AW[d]) - 1));
            if (p_wen[d] == 4'd0) begin
               exp_rd[d] = mm.exists(key) ? mm[key] : 32'hxxxxxxxx;
            end else begin
               w = mm.exists(key) ? mm[key] : 32'd0;
               for (int b = 0; b < 4; b++)
                  if (p_wen[d][b]) w[8*b +: 8] = p_wd[d][8*b +: 8];
               mm[key] = w;
            end
            pend[d] = 1'b0;
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic e0, input logic e3, input logic [3:0] w,
                      input logic [31:0] a, input logic [31:0] dat);
      en0 = e0; en3 = e3; wen = w; addr = a; wdata = dat;
   endtask

   initial begin
      rst = 1'b1;
      drv(0, 0, 4'h0, 32'h0, 32'h0);
      repeat (3) step;
      chk("reset rdata w0", rd0, 32'h0);
      chk("reset rdata w3", rd3, 32'h0);
      chk("reset stall w3", {31'd0, st3}, 32'h0);
      rst = 1'b0;

      // no wait states: full write then read
      drv(1, 0, 4'hF, 32'h10, 32'hDEADBEEF);
      #1 chk("w0 no stall", {31'd0, st0}, 32'h0);
      step;
      drv(1, 0, 4'h0, 32'h10, 32'h0);
      step;
      chk("w0 raw full", rd0, 32'hDEADBEEF);

      // byte lane 1 only
      drv(1, 0, 4'b0010, 32'h10, 32'h0000AA00); step;
      chk("w0 write holds rdata", rd0, 32'hDEADBEEF);
      drv(1, 0, 4'h0, 32'h10, 32'h0); step;
      chk("w0 byte lane", rd0, 32'hDEADAAEF);

      // back-to-back reads, wen=0 "write" is a read
      drv(1, 0, 4'hF, 32'h14, 32'h12345678); step;
      drv(1, 0, 4'h0, 32'h10, 32'h0); step;
      chk("w0 b2b first", rd0, 32'hDEADAAEF);
      drv(1, 0, 4'h0, 32'h14, 32'h0); step;
      chk("w0 b2b second", rd0, 32'h12345678);
      drv(1, 0, 4'h0, 32'h14, 32'hFFFFFFFF); step;
      chk("w0 wen0 is read", rd0, 32'h12345678);
      drv(1, 0, 4'h0, 32'h10, 32'h0); step;
      chk("w0 reread 0x10", rd0, 32'hDEADAAEF);
      drv(1, 0, 4'h0, 32'h14, 32'h0); step;
      chk("w0 0x14 unchanged", rd0, 32'h12345678);

      // aliasing with a 16-word memory
      drv(1, 0, 4'hF, 32'h40, 32'hCAFEF00D); step;
      drv(1, 0, 4'h0, 32'h00, 32'h0); step;
      chk("w0 alias", rd0, 32'hCAFEF00D);
      drv(0, 0, 4'h0, 32'h0, 32'h0);

      // three wait states: preload 0x20 and 0x30
      drv(0, 1, 4'hF, 32'h20, 32'hA5A5A5A5);
      #1 chk("w3 accept stall", {31'd0, st3}, 32'h1);
      step;
      drv(0, 0, 4'h0, 32'h0, 32'h0);
      repeat (4) step;
      drv(0, 1, 4'hF, 32'h30, 32'h87654321); step;
      drv(0, 0, 4'h0, 32'h0, 32'h0);
      repeat (4) step;

      // read 0x30 with garbage on the bus during WAIT
      drv(0, 1, 4'h0, 32'h30, 32'h0);
      #1 chk("w3 stall c1", {31'd0, st3}, 32'h1);
      step;
      drv(0, 1, 4'hF, 32'h30, 32'h0);
      #1 chk("w3 stall c2", {31'd0, st3}, 32'h1);
      step;
      drv(0, 1, 4'hF, 32'h7FC, 32'hFFFFFFFF);
      #1 chk("w3 stall c3", {31'd0, st3}, 32'h1);
      step;
      drv(0, 0, 4'h0, 32'h0, 32'h0);
      #1 chk("w3 stall drops", {31'd0, st3}, 32'h0);
      chk("w3 rdata not yet", rd3, 32'h0);
      step;
      chk("w3 rdata latched addr", rd3, 32'h87654321);
      drv(0, 1, 4'h0, 32'h30, 32'h0); step;
      drv(0, 0, 4'h0, 32'h0, 32'h0);
      repeat (3) step;
      chk("w3 garbage not written", rd3, 32'h87654321);

      // reset in the second stall cycle of a write
      drv(0, 1, 4'hF, 32'h20, 32'h11111111); step;
      drv(0, 0, 4'h0, 32'h0, 32'h0);
      rst = 1'b1;
      #1 chk("w3 rst stall", {31'd0, st3}, 32'h0);
      chk("w3 rst rdata", rd3, 32'h0);
      step;
      rst = 1'b0;
      drv(0, 1, 4'h0, 32'h20, 32'h0); step;
      drv(0, 0, 4'h0, 32'h0, 32'h0);
      repeat (3) step;
      chk("w3 aborted write", rd3, 32'hA5A5A5A5);

      // memory survives reset on the other instance too
      drv(1, 0, 4'h0, 32'h10, 32'h0); step;
      drv(0, 0, 4'h0, 32'h0, 32'h0);
      chk("w0 mem after reset", rd0, 32'hDEADAAEF);
      step;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
